mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_pkg.sv | 24 ++
 rtl/mult_div_step.sv | 36 +++
 rtl/mult_div_ctrl.sv | 123 ++++++++++++
 tb/tb_mult_div_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide controller.
// Build option: MULT_DIV_ZERO_EXC_EN (consumed by mult_div_ctrl).
package mult_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step on
// the 64-bit accumulator ({hi, lo} for MULT, {remainder, quotient} for DIV).
module mult_div_step
    import mult_div_pkg::*;
(
    input  logic        op_sel,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [31:0] shifted;
    logic [32:0] diff;

    always_comb begin
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        acc_next = acc;
        if (op_sel == OP_MULT) begin
            sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
            acc_next = {sum, acc[31:1]};
        end else begin
            // Partial remainder stays below the divisor, so the shifted value fits 32 bits.
            shifted = {acc[62:32], acc[31]};
            diff    = {1'b0, shifted} - {1'b0, operand};
            if (!diff[32]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {shifted, acc[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 signed multiply / divide controller with HI/LO result strobe.
// Build option: MULT_DIV_ZERO_EXC_EN makes divide-by-zero complete immediately with div_zero set.
module mult_div_ctrl
    import mult_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        hi_lo_write,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_zero
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [63:0]      acc;
    logic [63:0]      acc_next;
    logic [31:0]      mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             op_r;

    logic             neg;
    logic [63:0]      prod;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    mult_div_step u_step (
        .op_sel   (op_r),
        .acc      (acc),
        .operand  (mag_b),
        .acc_next (acc_next)
    );

    // Quotient sign fix is skipped for a zero divisor so the raw all-ones pattern survives.
    always_comb begin
        neg    = sign_a ^ sign_b;
        prod   = neg ? (64'd0 - acc) : acc;
        quo    = (neg && (mag_b != '0)) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem    = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
        res_hi = (op_r == OP_MULT) ? prod[63:32] : rem;
        res_lo = (op_r == OP_MULT) ? prod[31:0]  : quo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            acc         <= '0;
            mag_b       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            op_r        <= OP_MULT;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_lo_write <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            div_zero    <= 1'b0;
        end else begin
            done        <= 1'b0;
            hi_lo_write <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (op_start) begin
                        op_r     <= op_sel;
                        sign_a   <= src_a[31];
                        sign_b   <= src_b[31];
                        mag_b    <= magnitude(src_b);
                        acc      <= {32'd0, magnitude(src_a)};
                        count    <= CNT_W'(ITER_COUNT - 1);
                        div_zero <= 1'b0;
`ifdef MULT_DIV_ZERO_EXC_EN
                        if ((op_sel == OP_DIV) && (src_b == '0)) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state <= (op_sel == OP_DIV) ? ST_DIV : ST_MULT;
                            busy  <= 1'b1;
                        end
`else
                        state <= (op_sel == OP_DIV) ? ST_DIV : ST_MULT;
                        busy  <= 1'b1;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc <= acc_next;
                    if (count == '0) begin
                        state <= ST_FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_FIX: begin
                    hi_out      <= res_hi;
                    lo_out      <= res_lo;
                    done        <= 1'b1;
                    hi_lo_write <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl; honours MULT_DIV_ZERO_EXC_EN for divide-by-zero expectations.
module tb_mult_div_ctrl;

    logic        clock;
    logic        reset;
    logic        op_start;
    logic        op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        hi_lo_write;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    mult_div_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .op_start    (op_start),
        .op_sel      (op_sel),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .hi_lo_write (hi_lo_write),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_zero    (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        hlw;
        int          lat;
    } exp_t;

    exp_t        scb[$];
    int          tests_run;
    int          tests_failed;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    function automatic exp_t model(input bit op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dz  = 1'b0;
        e.hlw = 1'b1;
        e.lat = 34;
        if (!op) begin
            r    = sa * sb;
            e.hi = r[63:32];
            e.lo = r[31:0];
        end else if (b == 32'd0) begin
`ifdef MULT_DIV_ZERO_EXC_EN
            e.hi  = last_hi;
            e.lo  = last_lo;
            e.dz  = 1'b1;
            e.hlw = 1'b0;
            e.lat = 1;
`else
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
`endif
        end else begin
            r    = sa / sb;
            e.lo = r[31:0];
            r    = sa % sb;
            e.hi = r[31:0];
        end
        return e;
    endfunction

    // Called at a negedge; returns 1 time unit after the sampling edge.
    task automatic launch(input bit op, input logic [31:0] a, input logic [31:0] b);
        scb.push_back(model(op, a, b));
        op_sel   = op;
        src_a    = a;
        src_b    = b;
        op_start = 1'b1;
        @(posedge clock);
        #1 op_start = 1'b0;
    endtask

    // Counts negedges until done; optionally injects a stray op_start at negedge 'inject'.
    task automatic collect(input int inject, output int lat, output logic [31:0] hi, output logic [31:0] lo,
                           output logic dz, output logic hlw, output logic mid_busy,
                           output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        lat      = 0;
        mid_busy = 1'bx;
        mid_hi   = 'x;
        mid_lo   = 'x;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            op_start = 1'b0;
            if (lat == 10) begin
                mid_busy = busy;
                mid_hi   = hi_out;
                mid_lo   = lo_out;
            end
            if (done) break;
            if (lat == inject) begin
                op_start = 1'b1;
                op_sel   = ~op_sel;
                src_a    = 32'd9;
                src_b    = 32'd9;
            end
        end
        hi  = hi_out;
        lo  = lo_out;
        dz  = div_zero;
        hlw = hi_lo_write;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        op_start = 1'b0;
        op_sel   = 1'b0;
        src_a    = '0;
        src_b    = '0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({busy, done, hi_lo_write, div_zero} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got busy/done/hlw/dz=%b want 0000", {busy, done, hi_lo_write, div_zero});
        end
        tests_run++;
        if ({hi_out, lo_out} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_hilo got %h_%h want 0", hi_out, lo_out);
        end
        reset   = 1'b1;
        last_hi = '0;
        last_lo = '0;
        @(negedge clock);
    endtask

    task automatic run_table(input string name, input bit op, input logic [31:0] va[], input logic [31:0] vb[]);
        int          lat;
        logic [31:0] hi, lo, mhi, mlo;
        logic        dz, hlw, mbusy;
        exp_t        e;
        for (int i = 0; i < va.size(); i++) begin
            launch(op, va[i], vb[i]);
            collect(0, lat, hi, lo, dz, hlw, mbusy, mhi, mlo);
            e = scb.pop_front();
            tests_run++;
            if (lat !== e.lat || hi !== e.hi || lo !== e.lo || dz !== e.dz || hlw !== e.hlw) begin
                tests_failed++;
                $display("FAIL %s_result a=%h b=%h got lat=%0d hi=%h lo=%h dz=%b hlw=%b want lat=%0d hi=%h lo=%h dz=%b hlw=%b",
                         name, va[i], vb[i], lat, hi, lo, dz, hlw, e.lat, e.hi, e.lo, e.dz, e.hlw);
            end
            if (e.lat == 34) begin
                tests_run++;
                if (mbusy !== 1'b1 || mhi !== last_hi || mlo !== last_lo) begin
                    tests_failed++;
                    $display("FAIL %s_hold a=%h b=%h got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                             name, va[i], vb[i], mbusy, mhi, mlo, last_hi, last_lo);
                end
            end
            if (e.hlw) begin
                last_hi = e.hi;
                last_lo = e.lo;
            end
            @(negedge clock);
            tests_run++;
            if (done !== 1'b0 || hi_lo_write !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_pulse got done=%b hlw=%b busy=%b want 000", name, done, hi_lo_write, busy);
            end
        end
    endtask

    task automatic test_mult();
        logic [31:0] va[] = '{32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd5};
        logic [31:0] vb[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd12345, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'd0};
        run_table("mult", 1'b0, va, vb);
    endtask

    task automatic test_div();
        logic [31:0] va[] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd7, 32'd3};
        logic [31:0] vb[] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd10};
        run_table("div", 1'b1, va, vb);
    endtask

    task automatic test_div_zero();
        logic [31:0] va[] = '{32'd5, 32'hFFFF_FFF0};
        logic [31:0] vb[] = '{32'd0, 32'd0};
        run_table("divzero", 1'b1, va, vb);
        launch(1'b0, 32'd2, 32'd3);
        @(negedge clock);
        tests_run++;
        if (div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL divzero_clear got %b want 0", div_zero);
        end
        void'(scb.pop_front());
        repeat (40) @(negedge clock);
        last_hi = 32'd0;
        last_lo = 32'd6;
    endtask

    task automatic test_reset_mid();
        logic        seen_done;
        int          lat;
        logic [31:0] hi, lo, mhi, mlo;
        logic        dz, hlw, mbusy;
        exp_t        e;
        launch(1'b0, 32'h0000_1234, 32'h0000_5678);
        void'(scb.pop_back());
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, hi_lo_write, div_zero} !== 4'b0000 || {hi_out, lo_out} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid got busy/done/hlw/dz=%b hi=%h lo=%h want 0000 0 0",
                     {busy, done, hi_lo_write, div_zero}, hi_out, lo_out);
        end
        last_hi = '0;
        last_lo = '0;
        @(negedge clock);
        reset     = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen_done = seen_done | done | hi_lo_write | busy;
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet got activity=%b want 0", seen_done);
        end
        launch(1'b0, 32'd3, 32'd4);
        collect(0, lat, hi, lo, dz, hlw, mbusy, mhi, mlo);
        e = scb.pop_front();
        tests_run++;
        if (lat !== 34 || hi !== 32'd0 || lo !== 32'd12 || hlw !== 1'b1 || e.lo !== lo) begin
            tests_failed++;
            $display("FAIL reset_mid_after got lat=%0d hi=%h lo=%h hlw=%b want lat=34 hi=0 lo=c hlw=1",
                     lat, hi, lo, hlw);
        end
        last_hi = hi;
        last_lo = lo;
        @(negedge clock);
    endtask

    task automatic test_ignore();
        int          lat;
        logic [31:0] hi, lo, mhi, mlo;
        logic        dz, hlw, mbusy;
        exp_t        e;
        launch(1'b0, 32'd100, 32'hFFFF_FFFB);
        collect(5, lat, hi, lo, dz, hlw, mbusy, mhi, mlo);
        e = scb.pop_front();
        tests_run++;
        if (lat !== e.lat || hi !== e.hi || lo !== e.lo || hlw !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_start got lat=%0d hi=%h lo=%h hlw=%b want lat=%0d hi=%h lo=%h hlw=1",
                     lat, hi, lo, hlw, e.lat, e.hi, e.lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] hi, lo, mhi, mlo;
        logic        dz, hlw, mbusy;
        exp_t        e;
        launch(1'b1, 32'd1000, 32'd7);
        collect(0, lat, hi, lo, dz, hlw, mbusy, mhi, mlo);
        e = scb.pop_front();
        tests_run++;
        if (lat !== e.lat || hi !== e.hi || lo !== e.lo || hlw !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h", lat, hi, lo, e.lat, e.hi, e.lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        launch(1'b0, 32'hFFFF_FFFA, 32'd7);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        collect(0, lat, hi, lo, dz, hlw, mbusy, mhi, mlo);
        e = scb.pop_front();
        tests_run++;
        if (lat !== e.lat || hi !== e.hi || lo !== e.lo || hlw !== 1'b1 || mhi !== last_hi || mlo !== last_lo) begin
            tests_failed++;
            $display("FAIL b2b_second got lat=%0d hi=%h lo=%h mid=%h_%h want lat=%0d hi=%h lo=%h mid=%h_%h",
                     lat, hi, lo, mhi, mlo, e.lat, e.hi, e.lo, last_hi, last_lo);
        end
        @(negedge clock);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        tests_run++;
        if (scb.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got %0d left want 0", scb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
